hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide parameter: MEM_TIMEOUT, 64, max consecutive freeze cycles before fault (legal 2..255).
REQ-002 SHALL provide port: clk  input  1  rising-edge clock; single clock domain.
REQ-003 SHALL provide port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port: ID_rs1  input  5  rs1 of the instruction in ID.
REQ-005 SHALL provide port: ID_rs2  input  5  rs2 of the instruction in ID.
REQ-006 SHALL provide port: ID_uses_reg  input  2  [0] rs1 used, [1] rs2 used.
REQ-007 SHALL provide port: EXrd  input  5  destination register of the instruction in EX.
REQ-008 SHALL provide port: EXmemRead  input  1  instruction in EX is a load.
REQ-009 SHALL provide port: PCSel  input  1  control-flow redirect resolved in MEM this cycle.
REQ-010 SHALL provide port: dmem_req  input  1  MEM stage is accessing data memory.
REQ-011 SHALL provide port: dmem_ready  input  1  data memory completes the access this cycle.
REQ-012 SHALL provide port: hazard_signal  output  4  [0] hold_front (PC, IF/ID hold), [1] bubble_ex (ID/EX loads NOP), [2] flush_front (IF/ID, ID/EX, EX/MEM load NOP), [3] freeze_all (every pipe register holds).
REQ-013 SHALL provide port: mem_timeout  output  1  sticky memory-timeout fault.
REQ-014 SHALL provide port: state_dbg  output  2  current FSM state encoding.
REQ-015 SHALL provide port: perf_stall_cycles  output  32  stall-cycle counter.
REQ-016 SHALL provide port: perf_flushes  output  32  flush-event counter.

Function
REQ-017 SHALL implement FSM states RUN=00, WAIT=01, FLUSH=10, FAULT=11.
REQ-018 SHALL define load_use = EXmemRead && EXrd!=0 && ((ID_uses_reg[0] && EXrd==ID_rs1) || (ID_uses_reg[1] && EXrd==ID_rs2)).
REQ-019 SHALL define mem_stall = dmem_req && !dmem_ready.
REQ-020 SHALL drive hazard_signal combinationally from state and current inputs, at most one priority class active, priority freeze > flush > load-use.
REQ-021 Freeze class: freeze_all=1 in FAULT, or when mem_stall=1 in any state; all other bits 0.
REQ-022 Flush class: otherwise, when PCSel=1, flush_front=1 and all other bits 0; a redirect coincident with a load-use suppresses the stall.
REQ-023 Load-use class: otherwise, in RUN only, when load_use=1, hold_front=1 and bubble_ex=1; in FLUSH, load_use is ignored.
REQ-024 RUN transitions: mem_stall -> WAIT; else PCSel -> FLUSH; else stay in RUN.
REQ-025 WAIT transitions: dmem_ready=1 -> RUN, with that cycle non-frozen and PCSel honoured per REQ-022; freeze count reaching MEM_TIMEOUT with dmem_ready=0 -> FAULT.
REQ-026 Freeze counter: 8 bits; 1 in the entry cycle; +1 per consecutive mem_stall cycle; cleared on leaving WAIT; FAULT entered after exactly MEM_TIMEOUT freeze cycles.
REQ-027 FLUSH transitions: lasts one cycle; then mem_stall -> WAIT; else PCSel -> FLUSH; else RUN.
REQ-028 FAULT: absorbing until rst; mem_timeout=1; freeze_all=1 regardless of inputs.
REQ-029 A PCSel arriving during a freeze SHALL NOT be latched; the MEM stage holds it, so it takes effect in the first unfrozen cycle.

Reset
REQ-030 rst SHALL set state RUN, freeze counter 0, mem_timeout 0 and both perf counters 0, taking priority over every transition, including mid-WAIT and in FAULT.
REQ-031 In the cycle after reset, hazard_signal SHALL equal the RUN-state combinational result for the current inputs.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN defined: perf_stall_cycles increments each cycle hold_front|freeze_all=1, perf_flushes increments each cycle flush_front=1, both saturating at 32'hFFFFFFFF.
REQ-033 Macro HAZARD_PERF_CNT_EN undefined: both perf outputs tied to 0 and no counter flops synthesized.

Verification
REQ-034 Load-use: EXmemRead=1, EXrd=5, ID_rs1=5, ID_uses_reg=01 -> hazard_signal=0011 for one cycle; with EXrd=0 -> 0000.
REQ-035 Redirect: PCSel=1 in RUN -> hazard_signal=0100 that cycle, state_dbg=10 next cycle, load_use ignored in that FLUSH cycle.
REQ-036 Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles then ready -> hazard_signal=1000 for 3 cycles, 0000 on the ready cycle, state back to RUN.
REQ-037 Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> FAULT after 4 freeze cycles, mem_timeout=1 held; rst -> RUN, mem_timeout=0.
REQ-038 Simultaneous events: mem_stall+PCSel+load_use -> 1000; on ready -> 0100 -> FLUSH.
REQ-039 Perf counters: with HAZARD_PERF_CNT_EN, the REQ-036 sequence gives perf_stall_cycles=3 and perf_flushes=0; without the macro, both read 0.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard control bundle: ID/EX/MEM observation inputs and hazard/status outputs.
// master drives the pipeline observations, slave is the hazard controller.
interface hazard_ctrl_if;
  logic [4:0]  ID_rs1;
  logic [4:0]  ID_rs2;
  logic [1:0]  ID_uses_reg;
  logic [4:0]  EXrd;
  logic        EXmemRead;
  logic        PCSel;
  logic        dmem_req;
  logic        dmem_ready;
  logic [3:0]  hazard_signal;
  logic        mem_timeout;
  logic [1:0]  state_dbg;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_reg, EXrd, EXmemRead, PCSel, dmem_req, dmem_ready,
    input  hazard_signal, mem_timeout, state_dbg, perf_stall_cycles, perf_flushes
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_reg, EXrd, EXmemRead, PCSel, dmem_req, dmem_ready,
    output hazard_signal, mem_timeout, state_dbg, perf_stall_cycles, perf_flushes
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: freeze / flush / load-use stall FSM with memory-timeout fault.
// Optional saturating perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 64
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_if.slave hz
);
  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_WAIT  = 2'b01,
    ST_FLUSH = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [7:0] freeze_cnt_reg, freeze_cnt_next;
  logic [3:0] hazard;
  logic [1:0] src_match;
  logic [4:0] id_src [2];
  logic       load_use;
  logic       mem_stall;

  assign id_src[0] = hz.ID_rs1;
  assign id_src[1] = hz.ID_rs2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_match[gi] = hz.ID_uses_reg[gi] && (hz.EXrd == id_src[gi]);
    end
  endgenerate

  assign load_use  = hz.EXmemRead && (hz.EXrd != 5'd0) && (|src_match);
  assign mem_stall = hz.dmem_req && !hz.dmem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_RUN;
      freeze_cnt_reg <= 8'd0;
    end else begin
      state_reg      <= state_next;
      freeze_cnt_reg <= freeze_cnt_next;
    end
  end

  // PCSel is never latched while frozen; MEM keeps presenting it until a free cycle.
  always_comb begin
    state_next      = state_reg;
    freeze_cnt_next = 8'd0;
    case (state_reg)
      ST_RUN, ST_FLUSH: begin
        if (mem_stall) begin
          state_next      = ST_WAIT;
          freeze_cnt_next = 8'd1;
        end else if (hz.PCSel) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (mem_stall) begin
          freeze_cnt_next = freeze_cnt_reg + 8'd1;
          if (freeze_cnt_next == TIMEOUT) begin
            state_next = ST_FAULT;
          end
        end else if (hz.PCSel) begin
          state_next = ST_FLUSH;
        end else begin
          state_next = ST_RUN;
        end
      end
      default: begin
        state_next      = ST_FAULT;
        freeze_cnt_next = freeze_cnt_reg;
      end
    endcase
  end

  // One class at a time: freeze beats flush beats load-use.
  always_comb begin
    hazard = 4'b0000;
    if (state_reg == ST_FAULT || mem_stall) begin
      hazard[3] = 1'b1;
    end else if (hz.PCSel) begin
      hazard[2] = 1'b1;
    end else if (state_reg == ST_RUN && load_use) begin
      hazard[0] = 1'b1;
      hazard[1] = 1'b1;
    end
  end

  assign hz.hazard_signal = hazard;
  assign hz.state_dbg     = state_reg;
  assign hz.mem_timeout   = (state_reg == ST_FAULT);

`ifdef HAZARD_PERF_CNT_EN
  logic [1:0]       perf_inc;
  logic [1:0][31:0] perf_reg;

  assign perf_inc[0] = hazard[0] | hazard[3];
  assign perf_inc[1] = hazard[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_reg <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (perf_inc[i] && (perf_reg[i] != 32'hFFFF_FFFF)) begin
          perf_reg[i] <= perf_reg[i] + 32'd1;
        end
      end
    end
  end

  assign hz.perf_stall_cycles = perf_reg[0];
  assign hz.perf_flushes      = perf_reg[1];
`else
  assign hz.perf_stall_cycles = 32'd0;
  assign hz.perf_flushes      = 32'd0;
`endif
endmodule
